// File: rtl/segment_step_engine_if.sv
// FIFO read port and stepper driver pins of the segment step engine, bundled as one port.
interface segment_step_engine_if #(
   parameter int SEGMENT_BITS = 32
);
   logic                    data_available;
   logic                    data_request;
   logic [SEGMENT_BITS-1:0] data;
   logic                    enable;
   logic                    step_out;
   logic                    dir_out;
   logic                    busy;
   logic [14:0]             steps_remaining;

   modport slave (
      input  data_available, data, enable,
      output data_request, step_out, dir_out, busy, steps_remaining
   );

   modport master (
      output data_available, data, enable,
      input  data_request, step_out, dir_out, busy, steps_remaining
   );
endinterface

// File: rtl/segment_step_engine.sv
// Pops 32-bit motion segment records and plays them out as timed step pulses
// with direction setup; rising edges inside a segment are exactly one period apart.
//
// state     | meaning
// IDLE      | no segment; pop a record when one is available
// FETCH     | FIFO read latency; record is captured at the end of this cycle
// LOAD      | segment held; decide empty / direction change / first step
// DIR_WAIT  | dir_out changed, wait DIR_SETUP clocks before stepping
// STEP_HIGH | step_out high for PULSE_WIDTH clocks
// STEP_LOW  | step_out low for the rest of the effective period
module segment_step_engine #(
   parameter int PULSE_WIDTH = 8,
   parameter int DIR_SETUP   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   segment_step_engine_if.slave  bus
);
   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, DIR_WAIT, STEP_HIGH, STEP_LOW
   } state_t;

   localparam logic [16:0] MIN_PERIOD   = 17'(2 * PULSE_WIDTH);
   localparam logic [16:0] PW_LOAD      = 17'(PULSE_WIDTH - 1);
   localparam logic [16:0] SETUP_LOAD   = 17'(DIR_SETUP - 1);
   localparam logic [16:0] PW_PLUS_ONE  = 17'(PULSE_WIDTH + 1);

   state_t      state_q, state_d;
   logic [16:0] timer_q, timer_d;
   logic [16:0] period_q, period_d;
   logic [14:0] steps_q, steps_d;
   logic        seg_dir_q, seg_dir_d;
   logic        dir_q, dir_d;
   logic        req;
   logic [16:0] raw_period;
   logic [16:0] eff_period;

   assign raw_period = {1'b0, bus.data[15:0]};
   assign eff_period = (raw_period < MIN_PERIOD) ? MIN_PERIOD : raw_period;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         period_q  <= '0;
         steps_q   <= '0;
         seg_dir_q <= 1'b0;
         dir_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         period_q  <= period_d;
         steps_q   <= steps_d;
         seg_dir_q <= seg_dir_d;
         dir_q     <= dir_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      period_d  = period_q;
      steps_d   = steps_q;
      seg_dir_d = seg_dir_q;
      dir_d     = dir_q;
      req       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.data_available) begin
               req     = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            seg_dir_d = bus.data[31];
            steps_d   = bus.data[30:16];
            period_d  = eff_period;
            state_d   = LOAD;
         end
         LOAD: begin
            if (steps_q == '0) begin
               state_d = IDLE;
            end else if (seg_dir_q != dir_q) begin
               dir_d   = seg_dir_q;
               timer_d = SETUP_LOAD;
               state_d = DIR_WAIT;
            end else if (bus.enable) begin
               timer_d = PW_LOAD;
               steps_d = steps_q - 15'd1;
               state_d = STEP_HIGH;
            end
         end
         DIR_WAIT: begin
            if (timer_q != '0) begin
               timer_d = timer_q - 17'd1;
            end else if (bus.enable) begin
               timer_d = PW_LOAD;
               steps_d = steps_q - 15'd1;
               state_d = STEP_HIGH;
            end
         end
         STEP_HIGH: begin
            if (timer_q != '0) begin
               timer_d = timer_q - 17'd1;
            end else begin
               // low phase fills the period out to the next rising edge
               timer_d = period_q - PW_PLUS_ONE;
               state_d = STEP_LOW;
            end
         end
         STEP_LOW: begin
            if (timer_q != '0) begin
               timer_d = timer_q - 17'd1;
            end else if (steps_q == '0) begin
               state_d = IDLE;
            end else if (bus.enable) begin
               timer_d = PW_LOAD;
               steps_d = steps_q - 15'd1;
               state_d = STEP_HIGH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.data_request    = req;
   assign bus.step_out        = (state_q == STEP_HIGH);
   assign bus.dir_out         = dir_q;
   assign bus.busy            = (state_q == LOAD) || (state_q == DIR_WAIT) ||
                                (state_q == STEP_HIGH) || (state_q == STEP_LOW);
   assign bus.steps_remaining = steps_q;
endmodule
